// File: rtl/spi_serf_regs.sv
// SPI responder (mode 3, 16-bit frames) with an 8-bit register file.
// Register writes come from SPI write frames and from a host-side port.
// All SPI pins are asynchronous and are resynchronised into the clk domain.
module spi_serf_regs #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              frm_done,
    output logic [15:0]       rx_cmd
);

    typedef enum logic [1:0] {StIdle, StShft, StBprch} state_e;

    state_e      state_q;
    logic [2:0]  ss_ff_q;
    logic [2:0]  sclk_ff_q;
    logic [1:0]  mosi_ff_q;
    logic [1:0]  sync_vld_q;
    logic        ss_armed_q;
    logic [4:0]  bit_cnt_q;
    logic [15:0] tx_shft_q;
    logic [15:0] rx_shft_q;
    logic [7:0]  regs_q [DEPTH];

    logic        ss_fall;
    logic        ss_rise;
    logic        sclk_fall;
    logic        sclk_rise;
    logic        mosi_s;
    logic [15:0] rx_next;
    logic [6:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [6:0]  spi_addr;
    logic        spi_we;

    // Two-flop synchronisers, plus a third SS_n/SCLK stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_ff_q   <= 3'b111;
            sclk_ff_q <= 3'b111;
            mosi_ff_q <= 2'b00;
        end else begin
            ss_ff_q   <= {ss_ff_q[1:0], SS_n};
            sclk_ff_q <= {sclk_ff_q[1:0], SCLK};
            mosi_ff_q <= {mosi_ff_q[0], MOSI};
        end
    end

    // SS_n held low across reset release must not look like a fall: only arm fall
    // detection once the synchroniser has carried a real high level from the pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_vld_q <= 2'b00;
            ss_armed_q <= 1'b0;
        end else begin
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            if (sync_vld_q[1] && ss_ff_q[1]) begin
                ss_armed_q <= 1'b1;
            end
        end
    end

    assign ss_fall   = ss_armed_q & ~ss_ff_q[1] & ss_ff_q[2];
    assign ss_rise   = ss_ff_q[1] & ~ss_ff_q[2];
    assign sclk_fall = ~sclk_ff_q[1] & sclk_ff_q[2];
    assign sclk_rise = sclk_ff_q[1] & ~sclk_ff_q[2];
    assign mosi_s    = mosi_ff_q[1];

    assign rx_next  = {rx_shft_q[14:0], mosi_s};
    assign rd_addr  = rx_next[6:0];
    assign spi_addr = rx_shft_q[14:8];
    assign spi_we   = (state_q == StBprch) && ss_rise && !rx_shft_q[15]
                      && (32'(spi_addr) < DEPTH);

    // Read data lookup for the address completed by the 8th rise; unmapped reads 0.
    always_comb begin
        rd_data = 8'h00;
        if (32'(rd_addr) < DEPTH) begin
            rd_data = regs_q[rd_addr[ADDR_W-1:0]];
        end
    end

    // Frame FSM: shifts MOSI in on rises, MISO out on falls, commits on SS_n rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= 5'd0;
            tx_shft_q <= 16'h0000;
            rx_shft_q <= 16'h0000;
            MISO      <= 1'b0;
            frm_done  <= 1'b0;
            rx_cmd    <= 16'h0000;
        end else begin
            frm_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    MISO <= 1'b0;
                    if (ss_fall) begin
                        bit_cnt_q <= 5'd0;
                        tx_shft_q <= 16'h0000;
                        state_q   <= StShft;
                    end
                end
                StShft: begin
                    if (ss_rise) begin
                        // Aborted frame: discard everything.
                        MISO    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        if (sclk_fall) begin
                            MISO      <= tx_shft_q[15];
                            tx_shft_q <= {tx_shft_q[14:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            rx_shft_q <= rx_next;
                            if (bit_cnt_q < 5'd16) begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                            // Header complete: load read data into the upper byte.
                            if ((bit_cnt_q == 5'd7) && rx_next[7]) begin
                                tx_shft_q <= {rd_data, 8'h00};
                            end
                            if (bit_cnt_q == 5'd15) begin
                                state_q <= StBprch;
                            end
                        end
                    end
                end
                StBprch: begin
                    if (ss_rise) begin
                        rx_cmd   <= rx_shft_q;
                        frm_done <= 1'b1;
                        MISO     <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Register file; the SPI write is assigned last so it wins an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            if (host_wr && (32'(host_addr) < DEPTH)) begin
                regs_q[host_addr] <= host_wdata;
            end
            if (spi_we) begin
                regs_q[spi_addr[ADDR_W-1:0]] <= rx_shft_q[7:0];
            end
        end
    end

endmodule
